// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Source ids pick which writeback FIFO the round-robin pointer favours.
package reg_wb_arbiter_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending writebacks for one source.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module wb_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Full/empty depend only on registered pointers, so a pop in the same
  // cycle never frees a slot for the incoming push.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
               (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + (IDX_W+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (IDX_W+1)'(do_pop);
    head_o   = mem_q[rd_ptr_q[IDX_W-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges ALU and load writebacks onto the single register-file write port
// with round-robin arbitration and a per-register pending scoreboard.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ALU_VALID,
  input  logic [ADDR_W-1:0]   ALU_ADDR,
  input  logic [DATA_W-1:0]   ALU_DATA,
  output logic                ALU_READY,
  input  logic                MEM_VALID,
  input  logic [ADDR_W-1:0]   MEM_ADDR,
  input  logic [DATA_W-1:0]   MEM_DATA,
  output logic                MEM_READY,
  output logic                WRITEENABLE,
  output logic [ADDR_W-1:0]   WRITEREG,
  output logic [DATA_W-1:0]   WRITEDATA,
  output logic [NUM_REGS-1:0] PENDING
);

  wb_entry_t alu_in, mem_in, alu_head, mem_head, grant_entry;
  logic      alu_full, alu_empty, mem_full, mem_empty;
  logic      alu_push, mem_push, alu_pop, mem_pop;
  logic      grant_vld;
  src_e      grant_src;
  src_e      rr_q, rr_d;

  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;

  always_comb begin
    alu_in   = '{addr: ALU_ADDR, data: ALU_DATA};
    mem_in   = '{addr: MEM_ADDR, data: MEM_DATA};
    alu_push = ALU_VALID && !alu_full;
    mem_push = MEM_VALID && !mem_full;
  end

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (alu_push),
    .push_data_i (alu_in),
    .pop_i       (alu_pop),
    .head_o      (alu_head),
    .full_o      (alu_full),
    .empty_o     (alu_empty)
  );

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (mem_push),
    .push_data_i (mem_in),
    .pop_i       (mem_pop),
    .head_o      (mem_head),
    .full_o      (mem_full),
    .empty_o     (mem_empty)
  );

  // The pointer only advances when both sources compete for the port.
  always_comb begin
    grant_vld = !alu_empty || !mem_empty;
    grant_src = SRC_ALU;
    rr_d      = rr_q;
    if (!alu_empty && !mem_empty) begin
      grant_src = rr_q;
      rr_d      = other_src(rr_q);
    end else if (!mem_empty) begin
      grant_src = SRC_MEM;
    end
    grant_entry = (grant_src == SRC_MEM) ? mem_head : alu_head;
    alu_pop     = grant_vld && (grant_src == SRC_ALU);
    mem_pop     = grant_vld && (grant_src == SRC_MEM);
    we_d        = grant_vld;
    wreg_d      = grant_vld ? grant_entry.addr : wreg_q;
    wdata_d     = grant_vld ? grant_entry.data : wdata_q;
  end

  // Accepts and the retiring write land in the same update as a net change.
  always_comb begin
    pending_d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r]
               + CNT_W'(alu_push && (ALU_ADDR == ADDR_W'(r)))
               + CNT_W'(mem_push && (MEM_ADDR == ADDR_W'(r)))
               - CNT_W'(we_q && (wreg_q == ADDR_W'(r)));
      pending_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_q      <= SRC_ALU;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    ALU_READY   = !alu_full;
    MEM_READY   = !mem_full;
    WRITEENABLE = we_q;
    WRITEREG    = wreg_q;
    WRITEDATA   = wdata_q;
    PENDING     = pending_q;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized scoreboard bench for reg_wb_arbiter: a queue-level model predicts
// each register write, which a separate monitor checks as it appears.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic                ALU_VALID = 1'b0;
  logic [ADDR_W-1:0]   ALU_ADDR = '0;
  logic [DATA_W-1:0]   ALU_DATA = '0;
  logic                ALU_READY;
  logic                MEM_VALID = 1'b0;
  logic [ADDR_W-1:0]   MEM_ADDR = '0;
  logic [DATA_W-1:0]   MEM_DATA = '0;
  logic                MEM_READY;
  logic                WRITEENABLE;
  logic [ADDR_W-1:0]   WRITEREG;
  logic [DATA_W-1:0]   WRITEDATA;
  logic [NUM_REGS-1:0] PENDING;

  reg_wb_arbiter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ALU_VALID   (ALU_VALID),
    .ALU_ADDR    (ALU_ADDR),
    .ALU_DATA    (ALU_DATA),
    .ALU_READY   (ALU_READY),
    .MEM_VALID   (MEM_VALID),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_DATA    (MEM_DATA),
    .MEM_READY   (MEM_READY),
    .WRITEENABLE (WRITEENABLE),
    .WRITEREG    (WRITEREG),
    .WRITEDATA   (WRITEDATA),
    .PENDING     (PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } req_t;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_t;

  req_t        q_alu[$];
  req_t        q_mem[$];
  wr_t         exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned model_rf [NUM_REGS];
  int unsigned mon_rf [NUM_REGS];
  bit          rr_mem = 1'b0;
  bit          disp_vld = 1'b0;
  int unsigned disp_addr = 0;
  bit          prev_rst = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: each write seen on the port must be the next predicted one.
  always @(negedge CLK) begin
    bit  exp_we;
    wr_t e;
    exp_we = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
    chk("write_enable", 32'(WRITEENABLE), 32'(exp_we));
    if (exp_we) begin
      e = exp_q.pop_front();
      if (WRITEENABLE) begin
        chk("write_reg", 32'(WRITEREG), e.addr);
        chk("write_data", 32'(WRITEDATA), e.data);
      end
    end
    if (WRITEENABLE === 1'b1) mon_rf[WRITEREG] = 32'(WRITEDATA);
  end

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit rst,
                      input bit av, input int unsigned aa, input int unsigned ad,
                      input bit mv, input int unsigned ma, input int unsigned md);
    logic [NUM_REGS-1:0] pend;
    int unsigned         na, nm;
    int                  g;
    req_t                r;
    @(negedge CLK);
    #1;
    pend = '0;
    foreach (q_alu[i]) pend[q_alu[i].addr] = 1'b1;
    foreach (q_mem[i]) pend[q_mem[i].addr] = 1'b1;
    if (disp_vld) pend[disp_addr] = 1'b1;
    chk("pending", 32'(PENDING), 32'(pend));
    chk("alu_ready", 32'(ALU_READY), 32'(q_alu.size() < 2));
    chk("mem_ready", 32'(MEM_READY), 32'(q_mem.size() < 2));
    if (prev_rst) begin
      chk("reset_writereg", 32'(WRITEREG), 0);
      chk("reset_writedata", 32'(WRITEDATA), 0);
    end
    RESET     = rst;
    ALU_VALID = av;
    ALU_ADDR  = ADDR_W'(aa);
    ALU_DATA  = DATA_W'(ad);
    MEM_VALID = mv;
    MEM_ADDR  = ADDR_W'(ma);
    MEM_DATA  = DATA_W'(md);
    prev_rst  = rst;
    if (rst) begin
      q_alu.delete();
      q_mem.delete();
      rr_mem   = 1'b0;
      disp_vld = 1'b0;
    end else begin
      na = q_alu.size();
      nm = q_mem.size();
      g  = -1;
      if (na > 0 && nm > 0) begin
        g      = rr_mem ? 1 : 0;
        rr_mem = !rr_mem;
      end else if (na > 0) g = 0;
      else if (nm > 0) g = 1;
      if (g >= 0) begin
        r = (g == 1) ? q_mem.pop_front() : q_alu.pop_front();
        exp_q.push_back('{r.addr, r.data, cyc + 1});
        model_rf[r.addr] = r.data;
        disp_vld  = 1'b1;
        disp_addr = r.addr;
      end else begin
        disp_vld = 1'b0;
      end
      if (av && na < 2) q_alu.push_back('{aa % NUM_REGS, ad % 256});
      if (mv && nm < 2) q_mem.push_back('{ma % NUM_REGS, md % 256});
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      model_rf[i] = 0;
      mon_rf[i]   = 0;
    end
    // Reset held two cycles with both requests asserted.
    step(1'b1, 1'b1, 5, 11, 1'b1, 6, 12);
    step(1'b1, 1'b1, 5, 11, 1'b1, 6, 12);
    idle(2);
    // Single ALU write r2 = 95.
    step(1'b0, 1'b1, 2, 95, 1'b0, 0, 0);
    idle(3);
    // Both sources every cycle: alternating grants and back-pressure.
    for (int unsigned i = 0; i < 8; i++) step(1'b0, 1'b1, 1, 28 + i, 1'b1, 4, 6 + i);
    idle(6);
    // Back-to-back writes to r4 from different sources.
    step(1'b0, 1'b1, 4, 6, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b1, 4, 15);
    idle(4);
    // Same register, same cycle.
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 3, 7, 1'b1, 3, 9);
    idle(4);
    // Reset with writes queued: nothing queued may reach the port.
    step(1'b0, 1'b1, 5, 100, 1'b1, 6, 101);
    step(1'b0, 1'b1, 7, 102, 1'b1, 0, 103);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    idle(4);
    // Randomized traffic with occasional resets.
    for (int unsigned i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 255),
           $urandom_range(0, 3) != 0, $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 255));
    end
    idle(8);
    chk("drain_outstanding", exp_q.size(), 0);
    for (int i = 0; i < int'(NUM_REGS); i++) chk("regfile_contents", mon_rf[i], model_rf[i]);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
